// File: rtl/sumator_secvential_16bit.sv
// Slice-serial adder: one 4-bit carry-lookahead slice reused per cycle.
// LSB slice first; result, carry, overflow and group P/G held in DONE.
module sumator_secvential_16bit #(
  parameter int NSLICE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*NSLICE-1:0]   a,
  input  logic [4*NSLICE-1:0]   b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*NSLICE-1:0]   sum,
  output logic                  cout,
  output logic                  ovf,
  output logic                  P,
  output logic                  G
);

  localparam int W  = 4 * NSLICE;
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [KW-1:0]   r_k;
  logic            r_carry;
  logic            r_pacc;
  logic            r_gacc;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;
  logic            r_p;
  logic            r_g;

  logic [KW+1:0]   w_base;
  logic [3:0]      w_as;
  logic [3:0]      w_bs;
  logic [3:0]      w_p;
  logic [3:0]      w_g;
  logic [3:0]      w_c;
  logic            w_c4;
  logic [3:0]      w_s;
  logic            w_pg;
  logic            w_gg;
  logic            w_pacc_n;
  logic            w_gacc_n;

  assign w_base = {r_k, 2'b00};
  assign w_as   = r_a[w_base +: 4];
  assign w_bs   = r_b[w_base +: 4];

  // 4-bit carry-lookahead slice on the currently selected operand nibble
  always_comb begin
    w_p    = w_as ^ w_bs;
    w_g    = w_as & w_bs;
    w_c[0] = r_carry;
    w_c[1] = w_g[0] | (w_p[0] & r_carry);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0])
           | (w_p[1] & w_p[0] & r_carry);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1])
           | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & r_carry);
    w_c4   = w_g[3] | (w_p[3] & w_g[2])
           | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
    w_s    = w_p ^ w_c;
    w_pg   = &w_p;
    w_gg   = w_g[3] | (w_p[3] & w_g[2])
           | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  end

  // group terms folded with the running accumulators (cin excluded)
  assign w_pacc_n = r_pacc & w_pg;
  assign w_gacc_n = w_gg | (w_pg & r_gacc);

  // control FSM plus operand capture and per-slice result accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_pacc  <= 1'b1;
      r_gacc  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_p     <= 1'b0;
      r_g     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_k     <= '0;
            r_pacc  <= 1'b1;
            r_gacc  <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum[w_base +: 4] <= w_s;
          r_carry <= w_c4;
          r_pacc  <= w_pacc_n;
          r_gacc  <= w_gacc_n;
          r_k     <= r_k + KW'(1);
          if (r_k == KLAST) begin
            r_cout  <= w_c4;
            r_ovf   <= (r_a[W-1] == r_b[W-1])
                    && (w_s[3] != r_a[W-1]);
            r_p     <= w_pacc_n;
            r_g     <= w_gacc_n;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign P         = r_p;
  assign G         = r_g;

endmodule
